// File: rtl/gpu_cmd_parser.sv
// gpu_cmd_parser: command FIFO plus packet parser feeding the rasteriser.
// Words are buffered, assembled into draw/end-op packets, handed off via valid/ready.
module gpu_cmd_parser #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_write_data,
  input  logic        fifo_write,
  output logic        fifo_full,
  output logic        fifo_overflow,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [3:0]  pkt_op,
  output logic [7:0]  pkt_texnum,
  output logic [15:0] pkt_x1,
  output logic [15:0] pkt_y1,
  output logic [15:0] pkt_x2,
  output logic [15:0] pkt_y2,
  output logic [15:0] pkt_x3,
  output logic [15:0] pkt_y3,
  output logic        bad_cmd
);

  localparam logic [2:0] HDR = 3'd0;
  localparam logic [2:0] V1  = 3'd1;
  localparam logic [2:0] V2  = 3'd2;
  localparam logic [2:0] V3  = 3'd3;
  localparam logic [2:0] OUT = 3'd4;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q;

  logic [2:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic        bad_q, bad_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  tex_q, tex_d;
  logic [15:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic [15:0] x1_d, y1_d, x2_d, y2_d, x3_d, y3_d;

  logic        push, pop;
  logic [31:0] head;
  logic        unused_hdr_bits;

  // Occupancy never exceeds DEPTH, so the MSB alone marks full.
  assign fifo_full = cnt_q[AW];
  assign push = fifo_write && !fifo_full;
  assign pop  = (cnt_q != '0) && (state_q != OUT);
  assign head = mem_q[rd_ptr_q];
  assign unused_hdr_bits = ^head[27:8];

  // FIFO storage; contents need no reset, the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_write_data;
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
      if (fifo_write && fifo_full) ovf_q <= 1'b1;
    end
  end

  // Parser: gather header and vertices, then hold the packet for handoff.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    bad_d   = 1'b0;
    op_d    = op_q;
    tex_d   = tex_q;
    x1_d = x1_q; y1_d = y1_q;
    x2_d = x2_q; y2_d = y2_q;
    x3_d = x3_q; y3_d = y3_q;
    unique case (state_q)
      HDR: if (pop) begin
        unique case (head[31:28])
          4'd1: begin
            op_d    = 4'd1;
            tex_d   = head[7:0];
            state_d = V1;
          end
          4'd2: begin
            op_d  = 4'd2;
            tex_d = '0;
            x1_d = '0; y1_d = '0;
            x2_d = '0; y2_d = '0;
            x3_d = '0; y3_d = '0;
            state_d = OUT;
          end
          default: bad_d = 1'b1;
        endcase
      end
      V1: if (pop) begin
        x1_d = head[31:16];
        y1_d = head[15:0];
        state_d = V2;
      end
      V2: if (pop) begin
        x2_d = head[31:16];
        y2_d = head[15:0];
        state_d = V3;
      end
      V3: if (pop) begin
        x3_d = head[31:16];
        y3_d = head[15:0];
        state_d = OUT;
      end
      OUT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (pkt_ready) begin
          valid_d = 1'b0;
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Parser state and packet registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HDR;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      op_q    <= '0;
      tex_q   <= '0;
      x1_q <= '0; y1_q <= '0;
      x2_q <= '0; y2_q <= '0;
      x3_q <= '0; y3_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      op_q    <= op_d;
      tex_q   <= tex_d;
      x1_q <= x1_d; y1_q <= y1_d;
      x2_q <= x2_d; y2_q <= y2_d;
      x3_q <= x3_d; y3_q <= y3_d;
    end
  end

  assign fifo_overflow = ovf_q;
  assign pkt_valid     = valid_q;
  assign bad_cmd       = bad_q;
  assign pkt_op        = op_q;
  assign pkt_texnum    = tex_q;
  assign pkt_x1 = x1_q;
  assign pkt_y1 = y1_q;
  assign pkt_x2 = x2_q;
  assign pkt_y2 = y2_q;
  assign pkt_x3 = x3_q;
  assign pkt_y3 = y3_q;

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// tb_gpu_cmd_parser: packet-level scoreboard bench for gpu_cmd_parser.
// Expected packets are queued at issue time; a monitor pops them on handshake.
module tb_gpu_cmd_parser;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  tex;
    logic [15:0] x1, y1, x2, y2, x3, y3;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_write_data;
  logic        fifo_write;
  logic        fifo_full, fifo_overflow;
  logic        pkt_valid, pkt_ready;
  logic [3:0]  pkt_op;
  logic [7:0]  pkt_texnum;
  logic [15:0] pkt_x1, pkt_y1, pkt_x2, pkt_y2, pkt_x3, pkt_y3;
  logic        bad_cmd;

  always #5 clk = ~clk;

  gpu_cmd_parser #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .fifo_write_data(fifo_write_data),
    .fifo_write(fifo_write),
    .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_op(pkt_op), .pkt_texnum(pkt_texnum),
    .pkt_x1(pkt_x1), .pkt_y1(pkt_y1),
    .pkt_x2(pkt_x2), .pkt_y2(pkt_y2),
    .pkt_x3(pkt_x3), .pkt_y3(pkt_y3),
    .bad_cmd(bad_cmd)
  );

  pkt_t act;
  assign act = {pkt_op, pkt_texnum, pkt_x1, pkt_y1,
                pkt_x2, pkt_y2, pkt_x3, pkt_y3};

  pkt_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int bad_seen = 0;
  int bad_exp = 0;
  bit full_seen = 0;
  int ready_mode = 0;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // pkt_ready: 0 = held low, 1 = held high, 2 = random (max 2 low cycles).
  initial begin : ready_gen
    int lowrun;
    lowrun = 0;
    pkt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) pkt_ready = 1'b0;
      else if (ready_mode == 1) pkt_ready = 1'b1;
      else begin
        if (lowrun >= 2) pkt_ready = 1'b1;
        else pkt_ready = ($urandom_range(0, 3) != 0);
        lowrun = pkt_ready ? 0 : lowrun + 1;
      end
    end
  end

  // Monitor: handshake pops the scoreboard; stalled packets must hold still.
  pkt_t held;
  pkt_t e;
  bit   stalled = 0;
  always @(negedge clk) begin
    if (!reset) begin
      stalled = 0;
    end else begin
      if (bad_cmd) bad_seen++;
      if (fifo_full) full_seen = 1;
      if (pkt_valid) begin
        if (stalled) check("stable_while_stalled", act, held);
        if (pkt_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got %0h want none", act);
          end else begin
            e = exp_q.pop_front();
            check("pkt_fields", act, e);
          end
        end else begin
          stalled = 1;
          held = act;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_write = 1'b1;
    fifo_write_data = w;
    @(posedge clk);
    #1;
    fifo_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic pkt_t rnd_draw();
    pkt_t p;
    p.op  = 4'd1;
    p.tex = 8'($urandom);
    p.x1 = 16'($urandom); p.y1 = 16'($urandom);
    p.x2 = 16'($urandom); p.y2 = 16'($urandom);
    p.x3 = 16'($urandom); p.y3 = 16'($urandom);
    return p;
  endfunction

  // Header carries random ignored bits; vertices separated by random gaps.
  task automatic send_draw(input pkt_t p, input int gmin,
                           input int gmax, input bit expect_it);
    logic [31:0] v[3];
    v[0] = {p.x1, p.y1};
    v[1] = {p.x2, p.y2};
    v[2] = {p.x3, p.y3};
    push({4'd1, 20'($urandom), p.tex});
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(gmin, gmax));
      if (i == 2 && expect_it) exp_q.push_back(p);
      push(v[i]);
    end
  endtask

  // End-op: whatever the header carries, the packet has zero fields.
  task automatic send_end();
    pkt_t p;
    p = '0;
    p.op = 4'd2;
    exp_q.push_back(p);
    push({4'd2, 28'($urandom)});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(8);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    pkt_t p;
    int r;
    reset = 1'b0;
    fifo_write = 1'b0;
    fifo_write_data = '0;
    idle(2);
    reset = 1'b1;
    idle(1);

    // Reset state.
    check("rst_valid", pkt_valid, 0);
    check("rst_fields", act, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", fifo_overflow, 0);
    check("rst_bad", bad_cmd, 0);

    // Directed draw on alternate cycles; valid two edges after last push.
    ready_mode = 1;
    idle(1);
    p = '{op: 4'd1, tex: 8'd1, x1: 16'd10, y1: 16'd10,
          x2: 16'd10, y2: 16'd110, x3: 16'd110, y3: 16'd10};
    send_draw(p, 1, 1, 1);
    check("lat_e0", pkt_valid, 0);
    idle(1);
    check("lat_e1", pkt_valid, 0);
    idle(1);
    check("lat_e2", pkt_valid, 1);
    idle(1);
    check("valid_one_cycle", pkt_valid, 0);
    drain("drain_first", 50);

    // End op.
    send_end();
    drain("drain_endop", 50);
    check("endop_no_bad", bad_seen, 0);

    // Stalled rasteriser: the parser holds one packet, the FIFO DEPTH
    // more words, so words at index >= DEPTH+4 are dropped.
    ready_mode = 0;
    for (int k = 0; k < 6; k++)
      send_draw(rnd_draw(), 0, 0, (k * 4 + 3) < (DEPTH + 4));
    idle(4);
    check("stall_full", fifo_full, 1);
    check("stall_ovf", fifo_overflow, 1);
    check("stall_valid", pkt_valid, 1);
    idle(5);
    ready_mode = 1;
    drain("drain_stall", 300);
    check("ovf_sticky", fifo_overflow, 1);
    check("unfull", fifo_full, 0);
    do_reset();
    check("ovf_cleared", fifo_overflow, 0);

    // Unknown opcode header, then a draw packet.
    push({4'd7, 28'($urandom)});
    bad_exp = 1;
    send_draw(rnd_draw(), 0, 1, 1);
    drain("drain_badop", 100);
    check("bad_pulses", bad_seen, bad_exp);

    // Reset mid-packet discards the partial draw.
    push({4'd1, 28'($urandom)});
    push($urandom);
    push($urandom);
    idle(1);
    do_reset();
    check("midrst_valid", pkt_valid, 0);
    send_end();
    drain("drain_midrst", 100);
    check("midrst_ovf", fifo_overflow, 0);
    check("midrst_bad", bad_seen, bad_exp);

    // Ten back-to-back draw packets, one word per cycle, pointers wrap.
    full_seen = 0;
    for (int k = 0; k < 10; k++)
      send_draw(rnd_draw(), 0, 0, 1);
    drain("drain_burst", 400);
    check("burst_ovf", fifo_overflow, 0);
    check("burst_never_full", full_seen, 0);

    // Random mix with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) send_draw(rnd_draw(), 1, 3, 1);
      else if (r < 8) send_end();
      else begin
        push({4'($urandom_range(3, 15)), 28'($urandom)});
        bad_exp++;
      end
      idle($urandom_range(0, 2));
    end
    ready_mode = 1;
    drain("drain_random", 600);
    check("rand_ovf", fifo_overflow, 0);
    check("rand_bad", bad_seen, bad_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
